// File: rtl/next_field_sweep_pkg.sv
// Shared definitions for the next-generation field sweep.
// Field selector, neighbourhood size and sweep FSM encodings.
package next_field_sweep_pkg;

   typedef enum logic {
      FIELD_A = 1'b0,
      FIELD_B = 1'b1
   } field_t;

   localparam int NEIGHBOURS_CNT = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/next_cell_state.sv
// Life rule for one cell: birth on 3 live neighbours,
// survival on 2 or 3.
module next_cell_state
   import next_field_sweep_pkg::*;
(
   input  logic                      i_cell_state,
   input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
   output logic                      o_next_state
);

   logic [3:0] cnt;

   always_comb begin
      cnt = 4'($countones(i_nbrs));
      o_next_state = (cnt == 4'd3) | (i_cell_state & (cnt == 4'd2));
   end

endmodule

// File: rtl/next_field_sweep.sv
// Raster sweep over the read field, LANES cells per cycle,
// producing next-generation states for the write field.
module next_field_sweep
   import next_field_sweep_pkg::*;
#(
   parameter int FIELD_W = 16,
   parameter int FIELD_H = 16,
   parameter int LANES   = 4,
   parameter int GEN_W   = 16,
   localparam int X_ADR_SIZE = $clog2(FIELD_W),
   localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_go,
   input  logic                             i_run,
   input  logic                             i_stall,
   input  logic [LANES-1:0]                 i_next_cell_states,
   input  logic [LANES*NEIGHBOURS_CNT-1:0]  i_next_nbrs,
   output logic                             o_is_simulating,
   output logic [X_ADR_SIZE-1:0]            o_cur_x,
   output logic [Y_ADR_SIZE-1:0]            o_cur_y,
   output logic [X_ADR_SIZE-1:0]            o_next_x,
   output logic [Y_ADR_SIZE-1:0]            o_next_y,
   output logic [LANES-1:0]                 o_new_cur_cell_states,
   output logic                             o_wr_en,
   output field_t                           o_cur_read_field,
   output logic [GEN_W-1:0]                 o_gen_cnt,
   output logic                             o_done
);

   if (FIELD_W % LANES != 0) begin : g_bad_lanes
      $fatal(1, "FIELD_W must be a multiple of LANES");
   end

   localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - LANES);
   localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);
   localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES);

   logic [1:0]                        state_q, state_d;
   logic [X_ADR_SIZE-1:0]             next_x_q, next_x_d;
   logic [Y_ADR_SIZE-1:0]             next_y_q, next_y_d;
   logic [X_ADR_SIZE-1:0]             cur_x_q, cur_x_d;
   logic [Y_ADR_SIZE-1:0]             cur_y_q, cur_y_d;
   logic                              cur_valid_q, cur_valid_d;
   logic [LANES-1:0]                  lane_st_q, lane_st_d;
   logic [LANES*NEIGHBOURS_CNT-1:0]   lane_nb_q, lane_nb_d;
   field_t                            read_field_q, read_field_d;
   logic [GEN_W-1:0]                  gen_cnt_q, gen_cnt_d;
   logic                              done_q, done_d;

   always_comb begin
      state_d      = state_q;
      next_x_d     = next_x_q;
      next_y_d     = next_y_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      cur_valid_d  = cur_valid_q;
      lane_st_d    = lane_st_q;
      lane_nb_d    = lane_nb_q;
      read_field_d = read_field_q;
      gen_cnt_d    = gen_cnt_q;
      done_d       = done_q;
      if (!i_stall) begin
         unique case (state_q)
            ST_IDLE: begin
               done_d = 1'b0;
               if (i_go | i_run) begin
                  state_d     = ST_SWEEP;
                  cur_valid_d = 1'b0;
               end
            end
            ST_SWEEP: begin
               done_d      = 1'b0;
               lane_st_d   = i_next_cell_states;
               lane_nb_d   = i_next_nbrs;
               cur_x_d     = next_x_q;
               cur_y_d     = next_y_q;
               cur_valid_d = 1'b1;
               if (next_x_q == X_LAST) begin
                  next_x_d = '0;
                  if (next_y_q == Y_LAST) begin
                     next_y_d = '0;
                     state_d  = ST_DRAIN;
                  end else begin
                     next_y_d = next_y_q + 1'b1;
                  end
               end else begin
                  next_x_d = next_x_q + X_STEP;
               end
            end
            ST_DRAIN: begin
               state_d      = ST_IDLE;
               cur_valid_d  = 1'b0;
               read_field_d = (read_field_q == FIELD_A) ? FIELD_B : FIELD_A;
               gen_cnt_d    = gen_cnt_q + 1'b1;
               done_d       = 1'b1;
            end
            default: begin
               state_d     = ST_IDLE;
               cur_valid_d = 1'b0;
               next_x_d    = '0;
               next_y_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         next_x_q     <= '0;
         next_y_q     <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         cur_valid_q  <= 1'b0;
         lane_st_q    <= '0;
         lane_nb_q    <= '0;
         read_field_q <= FIELD_A;
         gen_cnt_q    <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         next_x_q     <= next_x_d;
         next_y_q     <= next_y_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         cur_valid_q  <= cur_valid_d;
         lane_st_q    <= lane_st_d;
         lane_nb_q    <= lane_nb_d;
         read_field_q <= read_field_d;
         gen_cnt_q    <= gen_cnt_d;
         done_q       <= done_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      next_cell_state u_cell (
         .i_cell_state (lane_st_q[i]),
         .i_nbrs       (lane_nb_q[i*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]),
         .o_next_state (o_new_cur_cell_states[i])
      );
   end

   assign o_is_simulating  = (state_q == ST_SWEEP) | (state_q == ST_DRAIN);
   assign o_cur_x          = cur_x_q;
   assign o_cur_y          = cur_y_q;
   assign o_next_x         = next_x_q;
   assign o_next_y         = next_y_q;
   assign o_wr_en          = cur_valid_q & ~i_stall & (state_q != ST_IDLE);
   assign o_cur_read_field = read_field_q;
   assign o_gen_cnt        = gen_cnt_q;
   assign o_done           = done_q;

endmodule

// File: tb/tb_next_field_sweep.sv
// Directed bench: 8x3/4-lane sweep with stalls, run mode,
// reset and counter wrap, plus a 5x3 single-lane raster.
module tb_next_field_sweep;
   import next_field_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic        go_a = 0, run_a = 0, stall_a = 0;
   logic [3:0]  cs_a;
   logic [31:0] nb_a;
   logic        sim_a, wr_a, done_a;
   logic [2:0]  cx_a, nx_a;
   logic [1:0]  cy_a, ny_a;
   logic [3:0]  new_a;
   field_t      fld_a;
   logic [1:0]  gen_a;

   logic        go_b = 0;
   logic [0:0]  cs_b;
   logic [7:0]  nb_b;
   logic        sim_b, wr_b, done_b;
   logic [2:0]  cx_b, nx_b;
   logic [1:0]  cy_b, ny_b;
   logic [0:0]  new_b;
   field_t      fld_b;
   logic [15:0] gen_b;

   next_field_sweep #(.FIELD_W(8), .FIELD_H(3), .LANES(4), .GEN_W(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_go(go_a), .i_run(run_a), .i_stall(stall_a),
      .i_next_cell_states(cs_a), .i_next_nbrs(nb_a),
      .o_is_simulating(sim_a), .o_cur_x(cx_a), .o_cur_y(cy_a),
      .o_next_x(nx_a), .o_next_y(ny_a), .o_new_cur_cell_states(new_a),
      .o_wr_en(wr_a), .o_cur_read_field(fld_a), .o_gen_cnt(gen_a), .o_done(done_a)
   );

   next_field_sweep #(.FIELD_W(5), .FIELD_H(3), .LANES(1), .GEN_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_go(go_b), .i_run(1'b0), .i_stall(1'b0),
      .i_next_cell_states(cs_b), .i_next_nbrs(nb_b),
      .o_is_simulating(sim_b), .o_cur_x(cx_b), .o_cur_y(cy_b),
      .o_next_x(nx_b), .o_next_y(ny_b), .o_new_cur_cell_states(new_b),
      .o_wr_en(wr_b), .o_cur_read_field(fld_b), .o_gen_cnt(gen_b), .o_done(done_b)
   );

   function automatic logic pat_st(int x, int y);
      return ((x * 3 + y) % 5) < 2;
   endfunction

   // neighbour counts 0,3,2,2,4,2,1,3 so births, survivals and deaths all occur
   function automatic logic [7:0] pat_nb(int x, int y);
      case ((x + 3 * y) % 8)
         0: return 8'h00;
         1: return 8'h07;
         2: return 8'h03;
         3: return 8'h81;
         4: return 8'h0F;
         5: return 8'hC0;
         6: return 8'h01;
         default: return 8'hE0;
      endcase
   endfunction

   function automatic logic life(logic s, logic [7:0] n);
      int c;
      c = $countones(n);
      return (c == 3) || (s && c == 2);
   endfunction

   always_comb begin
      cs_a = '0;
      nb_a = '0;
      for (int i = 0; i < 4; i++) begin
         cs_a[i] = pat_st(int'(nx_a) + i, int'(ny_a));
         nb_a[i*8 +: 8] = pat_nb(int'(nx_a) + i, int'(ny_a));
      end
      cs_b[0] = pat_st(int'(nx_b), int'(ny_b));
      nb_b = pat_nb(int'(nx_b), int'(ny_b));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_gen_a(input logic [15:0] stall_mask, input bit use_run,
                            input bit keep_run, input bit go_mid,
                            input int exp_gen, input field_t exp_fld);
      int f = 0;
      int cyc = 0;
      int strobes = 0;
      logic [3:0] ev;
      if (use_run) run_a = 1'b1;
      else go_a = 1'b1;
      @(posedge clk);
      #1;
      go_a = 1'b0;
      if (!keep_run) run_a = 1'b0;
      while (f <= 6 && cyc < 40) begin
         @(negedge clk);
         stall_a = stall_mask[cyc];
         go_a = go_mid && (cyc == 3);
         #1;
         chk("busy", 32'(sim_a), 1);
         chk("done_lo", 32'(done_a), 0);
         chk("nx", 32'(nx_a), (f < 6) ? (f % 2) * 4 : 0);
         chk("ny", 32'(ny_a), (f < 6) ? f / 2 : 0);
         chk("wr_en", 32'(wr_a), 32'(f >= 1 && !stall_a));
         if (f >= 1) begin
            chk("cx", 32'(cx_a), ((f - 1) % 2) * 4);
            chk("cy", 32'(cy_a), (f - 1) / 2);
            for (int i = 0; i < 4; i++)
               ev[i] = life(pat_st(((f - 1) % 2) * 4 + i, (f - 1) / 2),
                            pat_nb(((f - 1) % 2) * 4 + i, (f - 1) / 2));
            chk("new", 32'(new_a), 32'(ev));
         end
         if (wr_a) strobes++;
         if (!stall_a) f++;
         cyc++;
      end
      chk("bound_a", 32'(cyc < 40), 1);
      @(negedge clk);
      stall_a = 1'b0;
      go_a = 1'b0;
      #1;
      chk("strobes_a", 32'(strobes), 6);
      chk("done_hi", 32'(done_a), 1);
      chk("idle", 32'(sim_a), 0);
      chk("wr_idle", 32'(wr_a), 0);
      chk("gen", 32'(gen_a), 32'(exp_gen));
      chk("field", 32'(fld_a), 32'(exp_fld));
   endtask

   task automatic run_gen_b();
      int f = 0;
      int cyc = 0;
      int strobes = 0;
      go_b = 1'b1;
      @(posedge clk);
      #1;
      go_b = 1'b0;
      while (f <= 15 && cyc < 40) begin
         @(negedge clk);
         #1;
         chk("b_wr", 32'(wr_b), 32'(f >= 1));
         if (f >= 1) begin
            chk("b_cx", 32'(cx_b), (f - 1) % 5);
            chk("b_cy", 32'(cy_b), (f - 1) / 5);
            chk("b_new", 32'(new_b),
                32'(life(pat_st((f - 1) % 5, (f - 1) / 5), pat_nb((f - 1) % 5, (f - 1) / 5))));
         end
         if (wr_b) strobes++;
         if (go_b == 1'b0 && cyc == 4) go_b = 1'b1;
         else go_b = 1'b0;
         f++;
         cyc++;
      end
      go_b = 1'b0;
      @(negedge clk);
      #1;
      chk("b_strobes", 32'(strobes), 15);
      chk("b_done", 32'(done_b), 1);
      chk("b_gen", 32'(gen_b), 1);
      chk("b_field", 32'(fld_b), 32'(FIELD_B));
   endtask

   initial begin
      #12;
      chk("rst_busy", 32'(sim_a), 0);
      chk("rst_wr", 32'(wr_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_gen", 32'(gen_a), 0);
      chk("rst_field", 32'(fld_a), 32'(FIELD_A));
      chk("rst_nxy", 32'({nx_a, ny_a}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_hold", 32'(sim_a), 0);

      run_gen_a(16'h0000, 1'b0, 1'b0, 1'b0, 1, FIELD_B);
      run_gen_a(16'h001C, 1'b0, 1'b0, 1'b0, 2, FIELD_A);
      run_gen_a(16'h0000, 1'b0, 1'b0, 1'b1, 3, FIELD_B);
      run_gen_a(16'h0000, 1'b0, 1'b0, 1'b0, 0, FIELD_A);

      go_a = 1'b1;
      @(posedge clk);
      #1;
      go_a = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(sim_a), 0);
      chk("mid_rst_wr", 32'(wr_a), 0);
      chk("mid_rst_gen", 32'(gen_a), 0);
      chk("mid_rst_field", 32'(fld_a), 32'(FIELD_A));
      chk("mid_rst_cur", 32'({cx_a, cy_a}), 0);
      chk("mid_rst_next", 32'({nx_a, ny_a}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_idle", 32'(sim_a), 0);

      run_gen_a(16'h0000, 1'b1, 1'b1, 1'b0, 1, FIELD_B);
      run_gen_a(16'h0000, 1'b1, 1'b1, 1'b0, 2, FIELD_A);
      run_gen_a(16'h0000, 1'b1, 1'b0, 1'b0, 3, FIELD_B);
      @(negedge clk);
      #1;
      chk("run_stop", 32'(sim_a), 0);

      run_gen_b();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
